// File: rtl/cpu_debug_pkg.sv
// cpu_debug_pkg: shared types and constants for the debug on-chip memory slice.
//   - FSM state and pending-command enums
//   - jdo field bit positions and datapath widths
package cpu_debug_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned JDO_W     = 38;

  // jdo field positions
  localparam int unsigned ADDR_LSB  = 26;
  localparam int unsigned WDATA_LSB = 3;
  localparam int unsigned RD_BIT    = 35;
  localparam int unsigned INC_BIT   = 36;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_J_RD  = 3'd1,
    ST_J_CAP = 3'd2,
    ST_J_WR  = 3'd3,
    ST_C_RD  = 3'd4,
    ST_C_CAP = 3'd5,
    ST_C_WR  = 3'd6,
    ST_C_ACK = 3'd7
  } ocimem_state_e;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_NEXT  = 2'd2,
    CMD_WRITE = 2'd3
  } ocimem_cmd_e;

endpackage

// File: rtl/cpu_debug_ocimem_ctrl_if.sv
// cpu_debug_ocimem_ctrl_if: JTAG-wrapper and CPU Avalon-MM signals of the debug
// memory controller.
//   slave  : controller side (consumes jdo/strobes/avs requests, drives results)
//   master : wrapper/CPU side
interface cpu_debug_ocimem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  import cpu_debug_pkg::*;

  logic [JDO_W-1:0]  jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [DATA_W-1:0] MonDReg;
  logic              monitor_ready;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_chipselect;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [BE_W-1:0]   avs_byteenable;
  logic              avs_debugaccess;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    input  avs_byteenable, avs_debugaccess,
    output MonDReg, monitor_ready, avs_readdata, avs_waitrequest
  );

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    output avs_byteenable, avs_debugaccess,
    input  MonDReg, monitor_ready, avs_readdata, avs_waitrequest
  );

endinterface

// File: rtl/cpu_debug_ocimem_ram.sv
// cpu_debug_ocimem_ram: single-port debug RAM, byte-enabled write, 1-cycle
// registered read. Contents are never reset.
//   clk   : clock
//   addr  : word address
//   we/be : write enable and byte lanes
//   wdata : write data
//   q     : read data of the address presented on the previous edge
module cpu_debug_ocimem_ram
  import cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write plus read-first registered output
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// cpu_debug_ocimem_ctrl: JTAG-driven debug RAM access with a CPU Avalon-MM slave
// port sharing the same RAM; pending JTAG commands win arbitration in IDLE.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : jdo/strobes in, MonDReg/monitor_ready out,
//                  avs_* request in, avs_readdata/avs_waitrequest out
module cpu_debug_ocimem_ctrl
  import cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  cpu_debug_ocimem_ctrl_if.slave  bus
);

  ocimem_state_e     state_q, state_d;
  ocimem_cmd_e       pend_q, strobe_cmd_c;
  logic [ADDR_W-1:0] jaddr_q;
  logic              jinc_q;
  logic [DATA_W-1:0] mon_dreg_q, readdata_q;
  logic              mon_ready_q, waitreq_q;

  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_we_c;
  logic [BE_W-1:0]   ram_be_c;
  logic [DATA_W-1:0] ram_wdata_c, ram_q;
  logic              dispatch_c, load_c, next_c, jwr_c, jcap_c, ccap_c;

  logic [ADDR_W-1:0] jdo_addr_c;
  logic [DATA_W-1:0] jdo_wdata_c;
  logic              unused_jdo_c;

  assign jdo_addr_c   = bus.jdo[ADDR_LSB +: ADDR_W];
  assign jdo_wdata_c  = bus.jdo[WDATA_LSB +: DATA_W];
  assign unused_jdo_c = ^{bus.jdo[WDATA_LSB-1:0], bus.jdo[JDO_W-1]};

  // Strobe decode; simultaneous strobes are a protocol error, any pick is fine
  always_comb begin
    strobe_cmd_c = CMD_NONE;
    if (bus.take_action_ocimem_a)         strobe_cmd_c = CMD_LOAD;
    else if (bus.take_no_action_ocimem_a) strobe_cmd_c = CMD_NEXT;
    else if (bus.take_action_ocimem_b)    strobe_cmd_c = CMD_WRITE;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; a strobe arriving this edge also blocks the CPU so JTAG wins
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != CMD_NONE) begin
          unique case (pend_q)
            CMD_LOAD:  state_d = bus.jdo[RD_BIT] ? ST_J_RD : ST_IDLE;
            CMD_NEXT:  state_d = ST_J_RD;
            CMD_WRITE: state_d = ST_J_WR;
            default:   state_d = ST_IDLE;
          endcase
        end else if (strobe_cmd_c == CMD_NONE && bus.avs_chipselect) begin
          if (bus.avs_read)       state_d = ST_C_RD;
          else if (bus.avs_write) state_d = ST_C_WR;
        end
      end
      ST_J_RD:  state_d = ST_J_CAP;
      ST_J_CAP: state_d = ST_IDLE;
      ST_J_WR:  state_d = ST_IDLE;
      ST_C_RD:  state_d = ST_C_CAP;
      ST_C_CAP: state_d = ST_C_ACK;
      ST_C_WR:  state_d = ST_C_ACK;
      ST_C_ACK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: RAM port mux and datapath update enables
  always_comb begin
    ram_addr_c  = jaddr_q;
    ram_we_c    = 1'b0;
    ram_be_c    = '0;
    ram_wdata_c = jdo_wdata_c;
    dispatch_c  = 1'b0;
    load_c      = 1'b0;
    next_c      = 1'b0;
    jwr_c       = 1'b0;
    jcap_c      = 1'b0;
    ccap_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        dispatch_c = (pend_q != CMD_NONE);
        load_c     = (pend_q == CMD_LOAD);
        next_c     = (pend_q == CMD_NEXT);
      end
      ST_J_WR: begin
        ram_we_c = 1'b1;
        ram_be_c = '1;
        jwr_c    = 1'b1;
      end
      ST_J_CAP: jcap_c = 1'b1;
      ST_C_RD:  ram_addr_c = bus.avs_address;
      ST_C_CAP: ccap_c = 1'b1;
      ST_C_WR: begin
        ram_addr_c  = bus.avs_address;
        ram_we_c    = bus.avs_debugaccess;
        ram_be_c    = bus.avs_byteenable;
        ram_wdata_c = bus.avs_writedata;
      end
      default: ;
    endcase
  end

  // JTAG address/flags, pending command and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= CMD_NONE;
      jaddr_q     <= '0;
      jinc_q      <= 1'b0;
      mon_dreg_q  <= '0;
      mon_ready_q <= 1'b0;
      readdata_q  <= '0;
      waitreq_q   <= 1'b1;
    end else begin
      // A fresh strobe overrides a command being dispatched on the same edge
      if (strobe_cmd_c != CMD_NONE) pend_q <= strobe_cmd_c;
      else if (dispatch_c)          pend_q <= CMD_NONE;

      if (load_c) begin
        jaddr_q     <= jdo_addr_c;
        jinc_q      <= bus.jdo[INC_BIT];
        mon_ready_q <= 1'b0;
      end else if (next_c) begin
        jaddr_q     <= jaddr_q + ADDR_W'(1);
        mon_ready_q <= 1'b0;
      end else if (jwr_c && jinc_q) begin
        jaddr_q     <= jaddr_q + ADDR_W'(1);
      end

      if (jcap_c) begin
        mon_dreg_q  <= ram_q;
        mon_ready_q <= 1'b1;
      end
      if (ccap_c) readdata_q <= ram_q;

      waitreq_q <= (state_d != ST_C_ACK);
    end
  end

  assign bus.MonDReg         = mon_dreg_q;
  assign bus.monitor_ready   = mon_ready_q;
  assign bus.avs_readdata    = readdata_q;
  assign bus.avs_waitrequest = waitreq_q;

  cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr_c),
    .we    (ram_we_c),
    .be    (ram_be_c),
    .wdata (ram_wdata_c),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// tb_cpu_debug_ocimem_ctrl: scoreboard bench for the debug on-chip memory controller.
module tb_cpu_debug_ocimem_ctrl;

  localparam int unsigned ADDR_W = 8;

  logic clk;
  logic reset_n;

  cpu_debug_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_debug_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [256];
  logic [31:0] cpu_q [$];
  logic [31:0] jtag_q [$];

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [37:0] jdo_load(input logic [7:0] a, input bit rd, input bit inc);
    logic [37:0] j;
    j = '0;
    j[33:26] = a;
    j[35] = rd;
    j[36] = inc;
    return j;
  endfunction

  function automatic logic [37:0] jdo_wr(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One CPU transfer; entered and left 1 time unit after a rising edge
  task automatic cpu_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit dbg);
    bit acked;
    bus.avs_address     = a;
    bus.avs_writedata   = d;
    bus.avs_byteenable  = be;
    bus.avs_debugaccess = dbg;
    bus.avs_chipselect  = 1'b1;
    bus.avs_read        = !wr;
    bus.avs_write       = wr;
    if (wr) begin
      if (dbg) model[a] = merge(model[a], d, be);
    end else begin
      cpu_q.push_back(model[a]);
    end
    acked = 1'b0;
    for (int n = 0; n < 20 && !acked; n++) begin
      @(posedge clk);
      #1;
      if (!bus.avs_waitrequest) acked = 1'b1;
    end
    if (!acked) begin
      check32("cpu_ack_timeout", 32'd0, 32'd1);
      if (!wr) void'(cpu_q.pop_front());
    end else if (!wr) begin
      check32("cpu_rd_data", bus.avs_readdata, cpu_q.pop_front());
    end
    @(posedge clk);
    #1;
    bus.avs_chipselect = 1'b0;
    bus.avs_read       = 1'b0;
    bus.avs_write      = 1'b0;
    if (acked) check32("cpu_ack_one_cycle", 32'(bus.avs_waitrequest), 32'd1);
  endtask

  // kind 0 = LOAD, 1 = NEXT, 2 = WRITE; jdo is held until the next strobe
  task automatic jtag_strobe(input int kind, input logic [37:0] j);
    bus.jdo = j;
    bus.take_action_ocimem_a    = (kind == 0);
    bus.take_no_action_ocimem_a = (kind == 1);
    bus.take_action_ocimem_b    = (kind == 2);
    @(posedge clk);
    #1;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
  endtask

  // Called right after a read strobe's edge; expects data three edges later
  task automatic jtag_read_wait();
    bit got;
    got = 1'b0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check32("jrd_ready_drop", 32'(bus.monitor_ready), 32'd0);
      if (bus.monitor_ready) begin
        got = 1'b1;
        check32("jrd_latency", 32'(k), 32'd3);
        check32("jrd_data", bus.MonDReg, jtag_q.pop_front());
      end
    end
    if (!got) begin
      check32("jrd_timeout", 32'd0, 32'd1);
      void'(jtag_q.pop_front());
    end
  endtask

  initial begin
    bit jdone, cdone, cclose;
    int jat, cat;

    for (int i = 0; i < 256; i++) model[i] = '0;
    bus.jdo = '0;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.avs_address     = '0;
    bus.avs_chipselect  = 1'b0;
    bus.avs_read        = 1'b0;
    bus.avs_write       = 1'b0;
    bus.avs_writedata   = '0;
    bus.avs_byteenable  = '0;
    bus.avs_debugaccess = 1'b0;

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #20;
    check32("rst_waitrequest_in_reset", 32'(bus.avs_waitrequest), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    check32("rst_mondreg", bus.MonDReg, 32'd0);
    check32("rst_monitor_ready", 32'(bus.monitor_ready), 32'd0);
    check32("rst_readdata", bus.avs_readdata, 32'd0);
    check32("rst_waitrequest", 32'(bus.avs_waitrequest), 32'd1);

    // Preload through the CPU port
    cpu_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    cpu_xfer(1'b1, 8'h11, 32'h12345678, 4'hF, 1'b1);
    cpu_xfer(1'b1, 8'h20, 32'hCAFEF00D, 4'hF, 1'b1);
    cpu_xfer(1'b1, 8'h05, 32'h00000000, 4'hF, 1'b1);
    for (int i = 0; i < 16; i++) cpu_xfer(1'b1, 8'(8'h40 + i), $urandom, 4'hF, 1'b1);

    // JTAG LOAD with read, then NEXT
    jtag_q.push_back(model[8'h10]);
    jtag_strobe(0, jdo_load(8'h10, 1'b1, 1'b0));
    jtag_read_wait();
    idle(2);
    jtag_q.push_back(model[8'h11]);
    jtag_strobe(1, bus.jdo);
    jtag_read_wait();
    idle(2);

    // Auto-increment writes wrap from 0xFF to 0x00
    jtag_strobe(0, jdo_load(8'hFF, 1'b0, 1'b1));
    idle(3);
    jtag_strobe(2, jdo_wr(32'h1));
    model[8'hFF] = 32'h1;
    idle(3);
    jtag_strobe(2, jdo_wr(32'h2));
    model[8'h00] = 32'h2;
    idle(3);
    cpu_xfer(1'b0, 8'hFF, 32'h0, 4'hF, 1'b0);
    cpu_xfer(1'b0, 8'h00, 32'h0, 4'hF, 1'b0);

    // Re-read 0x10 so monitor_ready is high before the arbitration case
    jtag_q.push_back(model[8'h10]);
    jtag_strobe(0, jdo_load(8'h10, 1'b1, 1'b0));
    jtag_read_wait();
    idle(1);

    // CPU read and JTAG LOAD on the same edge: JTAG completes first
    bus.jdo = jdo_load(8'h10, 1'b1, 1'b0);
    bus.take_action_ocimem_a = 1'b1;
    bus.avs_address    = 8'h20;
    bus.avs_chipselect = 1'b1;
    bus.avs_read       = 1'b1;
    jtag_q.push_back(model[8'h10]);
    cpu_q.push_back(model[8'h20]);
    @(posedge clk);
    #1;
    bus.take_action_ocimem_a = 1'b0;
    jdone = 1'b0; cdone = 1'b0; cclose = 1'b0; jat = 0; cat = 0;
    for (int k = 1; k <= 20 && !(jdone && cclose); k++) begin
      @(posedge clk);
      #1;
      if (cdone && !cclose) begin
        cclose = 1'b1;
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        check32("arb_ack_one_cycle", 32'(bus.avs_waitrequest), 32'd1);
      end
      if (k == 1) check32("arb_ready_drop", 32'(bus.monitor_ready), 32'd0);
      if (!jdone && bus.monitor_ready) begin
        jdone = 1'b1;
        jat = k;
        check32("arb_jrd_data", bus.MonDReg, jtag_q.pop_front());
      end
      if (!cdone && !bus.avs_waitrequest) begin
        cdone = 1'b1;
        cat = k;
        check32("arb_cpu_data", bus.avs_readdata, cpu_q.pop_front());
      end
    end
    bus.avs_chipselect = 1'b0;
    bus.avs_read       = 1'b0;
    if (!(jdone && cclose)) begin
      check32("arb_timeout", 32'd0, 32'd1);
      jtag_q.delete();
      cpu_q.delete();
    end else begin
      check32("arb_jtag_latency", 32'(jat), 32'd3);
      check32("arb_jtag_first", 32'(jat < cat), 32'd1);
    end
    idle(2);

    // Byte-enabled CPU write, then the same write without debugaccess
    cpu_xfer(1'b1, 8'h05, 32'hAABBCCDD, 4'b0011, 1'b1);
    cpu_xfer(1'b0, 8'h05, 32'h0, 4'hF, 1'b0);
    check32("be_write_model", model[8'h05], 32'h0000CCDD);
    cpu_xfer(1'b1, 8'h05, 32'hAABBCCDD, 4'b0011, 1'b0);
    cpu_xfer(1'b0, 8'h05, 32'h0, 4'hF, 1'b0);

    // Mixed random CPU traffic over the preloaded window
    for (int i = 0; i < 12; i++) begin
      cpu_xfer(1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 15)), $urandom,
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) cpu_xfer(1'b0, 8'(8'h40 + 4 * i), 32'h0, 4'hF, 1'b0);

    // Reset while the FSM is in C_RD
    idle(1);
    bus.avs_address    = 8'h20;
    bus.avs_chipselect = 1'b1;
    bus.avs_read       = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check32("midrst_waitrequest", 32'(bus.avs_waitrequest), 32'd1);
    check32("midrst_monitor_ready", 32'(bus.monitor_ready), 32'd0);
    check32("midrst_mondreg", bus.MonDReg, 32'd0);
    bus.avs_chipselect = 1'b0;
    bus.avs_read       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    cpu_xfer(1'b0, 8'h20, 32'h0, 4'hF, 1'b0);
    jtag_q.push_back(model[8'h11]);
    jtag_strobe(0, jdo_load(8'h11, 1'b1, 1'b0));
    jtag_read_wait();

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
